// File: rtl/p88_loader_pkg.sv
// Shared types and constants for the P88 image loader: parser states,
// record command bytes and the far-JMP reset vector layout.
package p88_loader_pkg;

    typedef enum logic [4:0] {
        IDLE    = 5'd0,
        CMD     = 5'd1,
        S_SEGL  = 5'd2,
        S_SEGH  = 5'd3,
        S_OFFL  = 5'd4,
        S_OFFH  = 5'd5,
        S_SKIP0 = 5'd6,
        S_SKIP1 = 5'd7,
        S_LENL  = 5'd8,
        S_LENH  = 5'd9,
        S_DATA  = 5'd10,
        E_SEGL  = 5'd11,
        E_SEGH  = 5'd12,
        E_OFFL  = 5'd13,
        E_OFFH  = 5'd14,
        VEC     = 5'd15,
        ERR     = 5'd16
    } state_t;

    localparam logic [7:0] CMD_SECTION = 8'hC8;
    localparam logic [7:0] CMD_ENTRY   = 8'hCA;
    localparam logic [7:0] JMP_FAR     = 8'hEA;
    localparam int         VEC_LEN     = 5;

    // Byte idx of the reset vector "JMP FAR seg:off" (little-endian operands).
    function automatic logic [7:0] vec_byte(input logic [2:0] idx,
                                            input logic [15:0] seg,
                                            input logic [15:0] off);
        case (idx)
            3'd0:    vec_byte = JMP_FAR;
            3'd1:    vec_byte = off[7:0];
            3'd2:    vec_byte = off[15:8];
            3'd3:    vec_byte = seg[7:0];
            default: vec_byte = seg[15:8];
        endcase
    endfunction

endpackage

// File: rtl/p88_write_strobe.sv
// Write-strobe generator: after start, pulse stays high for WR_CYCLES cycles.
// Shared by the DRAM and vector ROM write paths.
module p88_write_strobe #(
    parameter int WR_CYCLES = 1
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic clear,
    input  logic start,
    output logic pulse,
    output logic busy
);

    logic [2:0] cnt_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cnt_q <= 3'd0;
        end else if (clear) begin
            cnt_q <= 3'd0;
        end else if (start) begin
            cnt_q <= 3'(WR_CYCLES);
        end else if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    assign pulse = (cnt_q != 3'd0);
    assign busy  = (cnt_q != 3'd0);

endmodule

// File: rtl/p88_image_loader.sv
// Parses a P88 image from the ioctl download stream, writes C8 sections to
// DRAM and CA entry records as a far-JMP into the boot vector ROM.
module p88_image_loader
    import p88_loader_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int LEN_W      = 16,
    parameter int WR_CYCLES  = 1,
    parameter int VEC_ADDR_W = 3,
    parameter int CNT_W      = 8
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [7:0]            ioctl_dout,
    output logic                  ioctl_wait,
    output logic                  hold_reset,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [7:0]            mem_data,
    output logic                  mem_we,
    output logic [VEC_ADDR_W-1:0] vec_addr,
    output logic                  vec_we,
    output logic                  entry_valid,
    output logic                  error,
    output logic [CNT_W-1:0]      sections,
    output logic [4:0]            state_dbg
);

    state_t            state_q, state_d;
    logic              dl_q, rise, fall, accept;
    logic [15:0]       seg_q, off_q;
    logic [LEN_W-1:0]  len_q, len_full_c;
    logic [ADDR_W-1:0] addr_q, base_c;
    logic              pend_q, data_done, vec_done, sec_inc;
    logic [1:0]        vphase_q;
    logic [2:0]        vidx_q;
    logic              str_start, str_clear, str_pulse, str_busy;

    assign rise       = ioctl_download & ~dl_q;
    assign fall       = ~ioctl_download & dl_q;
    // Handshake: a byte transfers on a cycle with ioctl_wr=1 and ioctl_wait=0;
    // download edges win over a coincident strobe.
    assign accept     = ioctl_wr & ~ioctl_wait & (state_q != IDLE) & ~rise & ~fall;
    assign base_c     = ADDR_W'({seg_q, 4'b0000}) + ADDR_W'(off_q);
    assign len_full_c = LEN_W'({ioctl_dout, len_q[7:0]});
    assign data_done  = pend_q & ~str_busy;
    assign vec_done   = (vphase_q == 2'd2) & ~str_busy & (vidx_q == 3'(VEC_LEN - 1));

    p88_write_strobe #(.WR_CYCLES(WR_CYCLES)) u_strobe (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clear   (str_clear),
        .start   (str_start),
        .pulse   (str_pulse),
        .busy    (str_busy)
    );

    assign mem_we    = str_pulse & (state_q == S_DATA);
    assign vec_we    = str_pulse & (state_q == VEC);
    assign state_dbg = state_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        str_start = 1'b0;
        str_clear = rise | fall;
        sec_inc   = 1'b0;
        if (fall) begin
            state_d = IDLE;
        end else if (rise) begin
            state_d = CMD;
        end else begin
            case (state_q)
                CMD: if (accept) begin
                    if (ioctl_dout == CMD_SECTION)    state_d = S_SEGL;
                    else if (ioctl_dout == CMD_ENTRY) state_d = E_SEGL;
                    else                              state_d = ERR;
                end
                S_SEGL:  if (accept) state_d = S_SEGH;
                S_SEGH:  if (accept) state_d = S_OFFL;
                S_OFFL:  if (accept) state_d = S_OFFH;
                S_OFFH:  if (accept) state_d = S_SKIP0;
                S_SKIP0: if (accept) state_d = S_SKIP1;
                S_SKIP1: if (accept) state_d = S_LENL;
                S_LENL:  if (accept) state_d = S_LENH;
                S_LENH:  if (accept) begin
                    sec_inc = (len_full_c == '0);
                    state_d = (len_full_c == '0) ? CMD : S_DATA;
                end
                S_DATA: begin
                    str_start = accept;
                    if (data_done && len_q == LEN_W'(1)) begin
                        sec_inc = 1'b1;
                        state_d = CMD;
                    end
                end
                E_SEGL:  if (accept) state_d = E_SEGH;
                E_SEGH:  if (accept) state_d = E_OFFL;
                E_OFFL:  if (accept) state_d = E_OFFH;
                E_OFFH:  if (accept) state_d = VEC;
                VEC: begin
                    str_start = (vphase_q == 2'd1);
                    if (vec_done) state_d = CMD;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dl_q        <= 1'b0;
            ioctl_wait  <= 1'b0;
            hold_reset  <= 1'b0;
            entry_valid <= 1'b0;
            error       <= 1'b0;
            sections    <= '0;
            mem_addr    <= '0;
            mem_data    <= 8'h00;
            vec_addr    <= '0;
            seg_q       <= 16'h0000;
            off_q       <= 16'h0000;
            len_q       <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            vphase_q    <= 2'd0;
            vidx_q      <= 3'd0;
        end else begin
            dl_q <= ioctl_download;
            if (fall) begin
                hold_reset <= 1'b0;
                ioctl_wait <= 1'b0;
                pend_q     <= 1'b0;
                if (state_q != CMD) error <= 1'b1;
            end else if (rise) begin
                hold_reset  <= 1'b1;
                ioctl_wait  <= 1'b0;
                pend_q      <= 1'b0;
                error       <= 1'b0;
                entry_valid <= 1'b0;
                sections    <= '0;
            end else begin
                if (ioctl_wr && ioctl_wait) error <= 1'b1;
                if (sec_inc && sections != '1) sections <= sections + 1'b1;
                case (state_q)
                    CMD: if (accept && ioctl_dout != CMD_SECTION && ioctl_dout != CMD_ENTRY)
                        error <= 1'b1;
                    S_SEGL, E_SEGL: if (accept) seg_q[7:0]  <= ioctl_dout;
                    S_SEGH, E_SEGH: if (accept) seg_q[15:8] <= ioctl_dout;
                    S_OFFL, E_OFFL: if (accept) off_q[7:0]  <= ioctl_dout;
                    S_OFFH:         if (accept) off_q[15:8] <= ioctl_dout;
                    S_LENL:         if (accept) len_q[7:0]  <= ioctl_dout;
                    S_LENH: if (accept) begin
                        len_q  <= len_full_c;
                        addr_q <= base_c;
                    end
                    S_DATA: begin
                        if (accept) begin
                            mem_data   <= ioctl_dout;
                            mem_addr   <= addr_q;
                            ioctl_wait <= 1'b1;
                            pend_q     <= 1'b1;
                        end
                        if (data_done) begin
                            addr_q     <= addr_q + 1'b1;
                            len_q      <= len_q - 1'b1;
                            pend_q     <= 1'b0;
                            ioctl_wait <= 1'b0;
                        end
                    end
                    E_OFFH: if (accept) begin
                        off_q[15:8] <= ioctl_dout;
                        ioctl_wait  <= 1'b1;
                        vphase_q    <= 2'd0;
                        vidx_q      <= 3'd0;
                    end
                    // Each vector byte: load addr/data, fire strobe, wait it out.
                    VEC: case (vphase_q)
                        2'd0: begin
                            vec_addr <= VEC_ADDR_W'(vidx_q);
                            mem_data <= vec_byte(vidx_q, seg_q, off_q);
                            vphase_q <= 2'd1;
                        end
                        2'd1: vphase_q <= 2'd2;
                        default: if (!str_busy) begin
                            vphase_q <= 2'd0;
                            if (vidx_q == 3'(VEC_LEN - 1)) begin
                                entry_valid <= 1'b1;
                                ioctl_wait  <= 1'b0;
                            end else begin
                                vidx_q <= vidx_q + 3'd1;
                            end
                        end
                    endcase
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_p88_image_loader.sv
// Directed bench for p88_image_loader: expected DRAM/vector writes are queued
// by the stimulus and consumed by a negedge monitor.
module tb_p88_image_loader;

    localparam int ADDR_W     = 20;
    localparam int LEN_W      = 16;
    localparam int WR_CYCLES  = 1;
    localparam int VEC_ADDR_W = 3;
    localparam int CNT_W      = 8;
    localparam int W          = 1 + ADDR_W + 8;

    logic                  clk_sys = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  ioctl_download = 1'b0;
    logic                  ioctl_wr = 1'b0;
    logic [7:0]            ioctl_dout = 8'h00;
    logic                  ioctl_wait, hold_reset, mem_we, vec_we, entry_valid, error;
    logic [ADDR_W-1:0]     mem_addr;
    logic [7:0]            mem_data;
    logic [VEC_ADDR_W-1:0] vec_addr;
    logic [CNT_W-1:0]      sections;
    logic [4:0]            state_dbg;

    int checks = 0;
    int errors = 0;
    int n_wait;
    logic [W-1:0] exp_q[$];

    always #5 clk_sys = ~clk_sys;

    p88_image_loader #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .WR_CYCLES(WR_CYCLES),
        .VEC_ADDR_W(VEC_ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .hold_reset(hold_reset),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .vec_addr(vec_addr), .vec_we(vec_we),
        .entry_valid(entry_valid), .error(error), .sections(sections),
        .state_dbg(state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        exp_q.push_back({1'b0, a, d});
    endtask

    task automatic exp_vec(input logic [VEC_ADDR_W-1:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, ADDR_W'(a), d});
    endtask

    // Monitor: every strobe cycle is one write (WR_CYCLES=1).
    always @(negedge clk_sys) begin
        logic [W-1:0] act, exp;
        if (mem_we || vec_we) begin
            act = vec_we ? {1'b1, ADDR_W'(vec_addr), mem_data} : {1'b0, mem_addr, mem_data};
            check("wait_during_write", 32'(ioctl_wait), 32'd1);
            if (mem_we) check("mem_we_excl_vec_we", 32'(vec_we), 32'd0);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %0h expected none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL write: got %0h expected %0h", act, exp);
                end
            end
        end
    end

    // Called on a negedge; returns on the negedge after the byte was sampled.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (ioctl_wait && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (ioctl_wait) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got wait=1 expected wait=0");
        end
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic count_wait(output int n);
        n = 0;
        while (ioctl_wait && n < 100) begin
            n++;
            @(negedge clk_sys);
        end
    endtask

    task automatic wait_ready();
        int n;
        count_wait(n);
        if (ioctl_wait) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got wait=1 expected wait=0");
        end
    endtask

    task automatic send_c8(input logic [15:0] seg, input logic [15:0] off, input logic [15:0] len);
        send_byte(8'hC8);
        send_byte(seg[7:0]); send_byte(seg[15:8]);
        send_byte(off[7:0]); send_byte(off[15:8]);
        send_byte(8'h00);    send_byte(8'h00);
        send_byte(len[7:0]); send_byte(len[15:8]);
    endtask

    task automatic send_ca(input logic [15:0] seg, input logic [15:0] off);
        send_byte(8'hCA);
        send_byte(seg[7:0]); send_byte(seg[15:8]);
        send_byte(off[7:0]); send_byte(off[15:8]);
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {18'd0, ioctl_wait, hold_reset, mem_we, vec_we,
                                entry_valid, error, sections}, 32'd0);
        check({name, "_bus"}, {1'b0, mem_addr, mem_data, vec_addr}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Section with three data bytes, then entry, wrap section, empty section.
        start_dl();
        check("hold_on_load", 32'(hold_reset), 32'd1);
        send_c8(16'h1234, 16'h0010, 16'h0003);
        exp_mem(20'h12350, 8'hAA); exp_mem(20'h12351, 8'hBB); exp_mem(20'h12352, 8'hCC);
        send_byte(8'hAA); count_wait(n_wait); check("wait_cycles_aa", n_wait, 32'd2);
        send_byte(8'hBB); count_wait(n_wait); check("wait_cycles_bb", n_wait, 32'd2);
        send_byte(8'hCC); count_wait(n_wait); check("wait_cycles_cc", n_wait, 32'd2);
        check("sections_after_c8", 32'(sections), 32'd1);
        check("error_after_c8", 32'(error), 32'd0);

        exp_vec(3'd0, 8'hEA); exp_vec(3'd1, 8'h00); exp_vec(3'd2, 8'h01);
        exp_vec(3'd3, 8'h00); exp_vec(3'd4, 8'hF0);
        send_ca(16'hF000, 16'h0100);
        check("wait_raised_by_ca", 32'(ioctl_wait), 32'd1);
        wait_ready();
        check("entry_valid", 32'(entry_valid), 32'd1);

        send_c8(16'hFFFF, 16'h0020, 16'h0002);
        exp_mem(20'h00010, 8'h11); exp_mem(20'h00011, 8'h22);
        send_byte(8'h11); send_byte(8'h22);
        wait_ready();
        check("sections_after_wrap", 32'(sections), 32'd2);

        send_c8(16'h1000, 16'h0000, 16'h0000);
        repeat (4) @(negedge clk_sys);
        check("sections_after_empty", 32'(sections), 32'd3);
        check("error_clean_image", 32'(error), 32'd0);
        end_dl();
        check("hold_released", 32'(hold_reset), 32'd0);
        check("error_clean_end", 32'(error), 32'd0);

        // Bad command byte: everything after it is discarded.
        start_dl();
        check("entry_cleared", 32'(entry_valid), 32'd0);
        check("sections_cleared", 32'(sections), 32'd0);
        send_byte(8'h55);
        check("error_bad_cmd", 32'(error), 32'd1);
        send_byte(8'hC8); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h77);
        repeat (4) @(negedge clk_sys);
        check("hold_in_err", 32'(hold_reset), 32'd1);
        end_dl();
        check("hold_after_err", 32'(hold_reset), 32'd0);
        check("error_kept", 32'(error), 32'd1);

        // Truncated data section.
        start_dl();
        check("error_clear_on_rise", 32'(error), 32'd0);
        send_c8(16'h1000, 16'h0000, 16'h0005);
        exp_mem(20'h10000, 8'h01); exp_mem(20'h10001, 8'h02);
        send_byte(8'h01); send_byte(8'h02);
        wait_ready();
        end_dl();
        check("error_truncated", 32'(error), 32'd1);
        check("hold_truncated", 32'(hold_reset), 32'd0);
        check("state_idle_truncated", 32'(state_dbg), 32'd0);

        // Clean restart, then a strobe during wait, then reset mid-write.
        start_dl();
        check("error_restart", 32'(error), 32'd0);
        check("sections_restart", 32'(sections), 32'd0);
        send_c8(16'h0000, 16'h0040, 16'h0001);
        exp_mem(20'h00040, 8'h5A);
        send_byte(8'h5A);
        wait_ready();
        check("sections_restart_c8", 32'(sections), 32'd1);
        check("error_restart_c8", 32'(error), 32'd0);

        send_c8(16'h0000, 16'h0050, 16'h0002);
        exp_mem(20'h00050, 8'h66); exp_mem(20'h00051, 8'h77);
        send_byte(8'h66);
        ioctl_wr   = 1'b1;
        ioctl_dout = 8'h99;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
        check("error_wr_during_wait", 32'(error), 32'd1);
        send_byte(8'h77);
        wait_ready();
        check("sections_after_ignored", 32'(sections), 32'd2);

        send_c8(16'h0000, 16'h0060, 16'h0001);
        exp_mem(20'h00060, 8'h3C);
        send_byte(8'h3C);
        check("mem_we_before_reset", 32'(mem_we), 32'd1);
        reset_n = 1'b0;
        @(negedge clk_sys);
        check_all_zero("mid_write_reset");
        ioctl_download = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);

        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
